// File: rtl/alu_sequencer_if.sv
// Command, ALU-control and result signals between the sequencer and its neighbours.
// slave = sequencer side, master = command source / ALU / result consumer side.
interface alu_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [4:0]       cmd_alu_op;
  logic [WIDTH-1:0] cmd_data;

  logic [4:0]       alu_opcode;
  logic [WIDTH-1:0] alu_operand;
  logic             alu_write;
  logic             alu_writeu;
  logic             alu_read;
  logic [WIDTH-1:0] alu_accout;
  logic             alu_flag;

  logic             result_valid;
  logic [WIDTH-1:0] result_data;
  logic             err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_alu_op, cmd_data, alu_accout, alu_flag,
    output cmd_ready, alu_opcode, alu_operand, alu_write, alu_writeu, alu_read,
           result_valid, result_data, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_alu_op, cmd_data, alu_accout, alu_flag,
    input  cmd_ready, alu_opcode, alu_operand, alu_write, alu_writeu, alu_read,
           result_valid, result_data, err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Command sequencer in front of the accumulator ALU: one command at a time,
// split 16-bit loads, accumulator readback and compare-flag capture.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a command; NOP and illegal EXEC stay here
// S_EXEC  | opcode/operand presented to the ALU for one cycle
// S_FLAG  | ALU flag valid; captured into result_data
// S_LD_LO | ALU write with low 12 bits of the load value
// S_LD_HI | ALU writeu with the upper nibble of the load value
// S_RD    | ALU read asserted; accumulator captured into result_data
module alu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.slave  bus
);

  localparam int LO_W = WIDTH - 4;

  localparam logic [1:0] CMD_NOP  = 2'd0;
  localparam logic [1:0] CMD_EXEC = 2'd1;
  localparam logic [1:0] CMD_LOAD = 2'd2;
  localparam logic [1:0] CMD_READ = 2'd3;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_CL   = 5'h0A;
  localparam logic [4:0] OP_CG   = 5'h0B;
  localparam logic [4:0] OP_CE   = 5'h0C;
  localparam logic [4:0] OP_LAST = 5'h0E;
  localparam logic [4:0] OP_NOTF = 5'h10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_FLAG,
    S_LD_LO,
    S_LD_HI,
    S_RD
  } state_t;

  state_t           r_state;
  logic [4:0]       r_alu_opcode;
  logic [WIDTH-1:0] r_alu_operand;
  logic             r_alu_write;
  logic             r_alu_writeu;
  logic             r_alu_read;
  logic             r_result_valid;
  logic [WIDTH-1:0] r_result_data;
  logic             r_err;
  logic [3:0]       r_hi_nib;

  state_t           w_nxt_state;
  logic [4:0]       w_alu_opcode;
  logic [WIDTH-1:0] w_alu_operand;
  logic             w_alu_write;
  logic             w_alu_writeu;
  logic             w_alu_read;
  logic             w_result_valid;
  logic [WIDTH-1:0] w_result_data;
  logic             w_err;
  logic [3:0]       w_hi_nib;
  logic             w_cmd_ready;
  logic             w_accept;
  logic             w_legal_op;
  logic             w_flag_op;

  assign w_cmd_ready = (r_state == S_IDLE) & ~rst;
  assign w_accept    = bus.cmd_valid & w_cmd_ready;

  assign w_legal_op  = (bus.cmd_alu_op <= OP_LAST) || (bus.cmd_alu_op == OP_NOTF);

  // r_alu_opcode still holds the latched opcode while in S_EXEC
  assign w_flag_op   = (r_alu_opcode == OP_CL) || (r_alu_opcode == OP_CG) ||
                       (r_alu_opcode == OP_CE) || (r_alu_opcode == OP_NOTF);

  // Outputs are computed for the state being entered and registered with it,
  // so each ALU control value lines up with the state that owns it.
  always_comb begin
    w_nxt_state    = r_state;
    w_alu_opcode   = OP_NOP;
    w_alu_operand  = '0;
    w_alu_write    = 1'b0;
    w_alu_writeu   = 1'b0;
    w_alu_read     = 1'b0;
    w_result_valid = 1'b0;
    w_result_data  = r_result_data;
    w_err          = 1'b0;
    w_hi_nib       = r_hi_nib;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (bus.cmd_op)
            CMD_NOP: begin
              w_nxt_state = S_IDLE;
            end
            CMD_EXEC: begin
              if (w_legal_op) begin
                w_nxt_state   = S_EXEC;
                w_alu_opcode  = bus.cmd_alu_op;
                w_alu_operand = bus.cmd_data;
              end else begin
                w_err = 1'b1;
              end
            end
            CMD_LOAD: begin
              w_nxt_state   = S_LD_LO;
              w_alu_write   = 1'b1;
              w_alu_operand = {4'b0000, bus.cmd_data[LO_W-1:0]};
              w_hi_nib      = bus.cmd_data[WIDTH-1 -: 4];
            end
            CMD_READ: begin
              w_nxt_state = S_RD;
              w_alu_read  = 1'b1;
            end
            default: begin
              w_nxt_state = S_IDLE;
            end
          endcase
        end
      end

      S_EXEC: begin
        w_nxt_state = w_flag_op ? S_FLAG : S_IDLE;
      end

      S_FLAG: begin
        w_nxt_state    = S_IDLE;
        w_result_valid = 1'b1;
        w_result_data  = {{(WIDTH-1){1'b0}}, bus.alu_flag};
      end

      S_LD_LO: begin
        w_nxt_state   = S_LD_HI;
        w_alu_writeu  = 1'b1;
        w_alu_operand = {{LO_W{1'b0}}, r_hi_nib};
      end

      S_LD_HI: begin
        w_nxt_state = S_IDLE;
      end

      S_RD: begin
        w_nxt_state    = S_IDLE;
        w_result_valid = 1'b1;
        w_result_data  = bus.alu_accout;
      end

      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_alu_opcode   <= OP_NOP;
      r_alu_operand  <= '0;
      r_alu_write    <= 1'b0;
      r_alu_writeu   <= 1'b0;
      r_alu_read     <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_data  <= '0;
      r_err          <= 1'b0;
      r_hi_nib       <= 4'h0;
    end else begin
      r_state        <= w_nxt_state;
      r_alu_opcode   <= w_alu_opcode;
      r_alu_operand  <= w_alu_operand;
      r_alu_write    <= w_alu_write;
      r_alu_writeu   <= w_alu_writeu;
      r_alu_read     <= w_alu_read;
      r_result_valid <= w_result_valid;
      r_result_data  <= w_result_data;
      r_err          <= w_err;
      r_hi_nib       <= w_hi_nib;
    end
  end

  assign bus.cmd_ready    = w_cmd_ready;
  assign bus.alu_opcode   = r_alu_opcode;
  assign bus.alu_operand  = r_alu_operand;
  assign bus.alu_write    = r_alu_write;
  assign bus.alu_writeu   = r_alu_writeu;
  assign bus.alu_read     = r_alu_read;
  assign bus.result_valid = r_result_valid;
  assign bus.result_data  = r_result_data;
  assign bus.err          = r_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small accumulator-ALU model attached
// to the ALU pins; expected values are hand-computed from the command stream.
module tb_alu_sequencer;

  logic clk;
  logic rst;

  alu_sequencer_if #(.WIDTH(16)) bus();

  alu_sequencer #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // accumulator ALU (not reset by rst)
  logic [15:0] acc  = 16'h0000;
  logic        flag = 1'b0;

  assign bus.alu_accout = acc;
  assign bus.alu_flag   = flag;

  always @(posedge clk) begin
    if (bus.alu_write) acc <= bus.alu_operand;
    else if (bus.alu_writeu) acc[15:12] <= bus.alu_operand[3:0];
    else if (bus.alu_opcode == 5'h01) acc <= acc + bus.alu_operand;
    case (bus.alu_opcode)
      5'h0A:   flag <= (acc < bus.alu_operand);
      5'h0B:   flag <= (acc > bus.alu_operand);
      5'h0C:   flag <= (acc == bus.alu_operand);
      5'h10:   flag <= ~flag;
      default: ;
    endcase
  end

  int checks = 0;
  int fails  = 0;

  int add_cycles = 0;
  int writeu_cnt = 0;
  int both_cnt   = 0;
  int rv_cnt     = 0;
  int rv_double  = 0;
  int err_cnt    = 0;
  int err_double = 0;
  logic prev_rv  = 1'b0;
  logic prev_err = 1'b0;

  always @(negedge clk) begin
    if (bus.alu_opcode == 5'h01) add_cycles++;
    if (bus.alu_writeu) writeu_cnt++;
    if (bus.alu_write && bus.alu_writeu) both_cnt++;
    if (bus.result_valid) rv_cnt++;
    if (bus.result_valid && prev_rv) rv_double++;
    if (bus.err) err_cnt++;
    if (bus.err && prev_err) err_double++;
    prev_rv  = bus.result_valid;
    prev_err = bus.err;
  end

  // Waits (bounded) for cmd_ready, presents one command for one accepting edge,
  // and returns at the falling edge just after acceptance with cmd_valid low.
  task automatic do_cmd(input logic [1:0] op, input logic [4:0] aop, input logic [15:0] d);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++; fails++;
      $display("FAIL cmd_ready_timeout: cmd_ready=%b required 1", bus.cmd_ready);
    end
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_alu_op = aop;
    bus.cmd_data   = d;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    int rv0, wu0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_alu_op = 5'd0; bus.cmd_data = 16'h0;
    @(negedge clk); @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", bus.cmd_ready); end
    checks++; if (bus.alu_opcode !== 5'h00 || bus.alu_operand !== 16'h0) begin fails++; $display("FAIL rst_alu: opcode=%h operand=%h want 00/0000", bus.alu_opcode, bus.alu_operand); end
    checks++; if ({bus.alu_write, bus.alu_writeu, bus.alu_read, bus.result_valid, bus.err} !== 5'b0) begin fails++; $display("FAIL rst_strobes: w/wu/rd/rv/err=%b want 00000", {bus.alu_write, bus.alu_writeu, bus.alu_read, bus.result_valid, bus.err}); end
    checks++; if (bus.result_data !== 16'h0) begin fails++; $display("FAIL rst_result: got %h want 0000", bus.result_data); end
    rst = 1'b0;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b want 1", bus.cmd_ready); end
    // reset while the low-half write of a LOAD is on the pins
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; bus.cmd_data = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.alu_write !== 1'b1) begin fails++; $display("FAIL mid_ldlo_write: got %b want 1", bus.alu_write); end
    rv0 = rv_cnt; wu0 = writeu_cnt;
    rst = 1'b1;
    #1;
    checks++; if (bus.alu_write !== 1'b0 || bus.alu_operand !== 16'h0) begin fails++; $display("FAIL async_rst: write=%b operand=%h want 0/0000", bus.alu_write, bus.alu_operand); end
    checks++; if (bus.cmd_ready !== 1'b0) begin fails++; $display("FAIL async_rst_ready: got %b want 0", bus.cmd_ready); end
    repeat (3) @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b0) begin fails++; $display("FAIL held_rst_ready: got %b want 0", bus.cmd_ready); end
    checks++; if (rv_cnt != rv0 || writeu_cnt != wu0) begin fails++; $display("FAIL rst_abort: rv delta=%0d writeu delta=%0d want 0/0", rv_cnt - rv0, writeu_cnt - wu0); end
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready: got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_load_read();
    int rv0;
    do_cmd(2'd2, 5'h00, 16'hBEEF);
    checks++; if (bus.alu_write !== 1'b1 || bus.alu_writeu !== 1'b0 || bus.alu_operand !== 16'h0EEF) begin fails++; $display("FAIL ld_lo: w=%b wu=%b operand=%h want 1/0/0EEF", bus.alu_write, bus.alu_writeu, bus.alu_operand); end
    @(negedge clk);
    checks++; if (bus.alu_writeu !== 1'b1 || bus.alu_write !== 1'b0 || bus.alu_operand !== 16'h000B) begin fails++; $display("FAIL ld_hi: w=%b wu=%b operand=%h want 0/1/000B", bus.alu_write, bus.alu_writeu, bus.alu_operand); end
    @(negedge clk);
    checks++; if (bus.alu_writeu !== 1'b0 || bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL ld_done: wu=%b ready=%b want 0/1", bus.alu_writeu, bus.cmd_ready); end
    rv0 = rv_cnt;
    do_cmd(2'd3, 5'h00, 16'h0000);
    checks++; if (bus.alu_read !== 1'b1 || bus.result_valid !== 1'b0) begin fails++; $display("FAIL rd_cycle: read=%b rv=%b want 1/0", bus.alu_read, bus.result_valid); end
    @(negedge clk);
    checks++; if (bus.result_valid !== 1'b1 || bus.result_data !== 16'hBEEF) begin fails++; $display("FAIL rd_result: rv=%b data=%h want 1/BEEF", bus.result_valid, bus.result_data); end
    @(negedge clk);
    checks++; if (bus.result_valid !== 1'b0 || bus.result_data !== 16'hBEEF) begin fails++; $display("FAIL rd_hold: rv=%b data=%h want 0/BEEF", bus.result_valid, bus.result_data); end
    checks++; if (rv_cnt - rv0 != 1) begin fails++; $display("FAIL rd_pulses: got %0d want 1", rv_cnt - rv0); end
  endtask

  task automatic test_exec_add();
    int a0;
    do_cmd(2'd2, 5'h00, 16'h0005);
    a0 = add_cycles;
    do_cmd(2'd1, 5'h01, 16'h0003);
    checks++; if (bus.alu_opcode !== 5'h01 || bus.alu_operand !== 16'h0003) begin fails++; $display("FAIL exec_add: opcode=%h operand=%h want 01/0003", bus.alu_opcode, bus.alu_operand); end
    @(negedge clk);
    checks++; if (bus.alu_opcode !== 5'h00) begin fails++; $display("FAIL exec_one_cycle: opcode=%h want 00", bus.alu_opcode); end
    do_cmd(2'd3, 5'h00, 16'h0000);
    @(negedge clk);
    checks++; if (bus.result_valid !== 1'b1 || bus.result_data !== 16'h0008) begin fails++; $display("FAIL add_result: rv=%b data=%h want 1/0008", bus.result_valid, bus.result_data); end
    checks++; if (add_cycles - a0 != 1) begin fails++; $display("FAIL add_cycles: got %0d want 1", add_cycles - a0); end
  endtask

  task automatic test_compare();
    do_cmd(2'd2, 5'h00, 16'h0002);
    do_cmd(2'd1, 5'h0A, 16'h0007);
    checks++; if (bus.alu_opcode !== 5'h0A || bus.alu_operand !== 16'h0007) begin fails++; $display("FAIL cl_issue: opcode=%h operand=%h want 0A/0007", bus.alu_opcode, bus.alu_operand); end
    @(negedge clk);
    checks++; if (bus.result_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin fails++; $display("FAIL cl_flag_cycle: rv=%b ready=%b want 0/0", bus.result_valid, bus.cmd_ready); end
    @(negedge clk);
    checks++; if (bus.result_valid !== 1'b1 || bus.result_data !== 16'h0001) begin fails++; $display("FAIL cl_result: rv=%b data=%h want 1/0001", bus.result_valid, bus.result_data); end
    do_cmd(2'd1, 5'h0C, 16'h0007);
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.result_valid !== 1'b1 || bus.result_data !== 16'h0000) begin fails++; $display("FAIL ce_result: rv=%b data=%h want 1/0000", bus.result_valid, bus.result_data); end
    do_cmd(2'd1, 5'h10, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.result_valid !== 1'b1 || bus.result_data !== 16'h0001) begin fails++; $display("FAIL notf_result: rv=%b data=%h want 1/0001", bus.result_valid, bus.result_data); end
  endtask

  task automatic test_illegal();
    do_cmd(2'd1, 5'h0F, 16'h1234);
    checks++; if (bus.err !== 1'b1 || bus.alu_opcode !== 5'h00) begin fails++; $display("FAIL ill_0f: err=%b opcode=%h want 1/00", bus.err, bus.alu_opcode); end
    checks++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL ill_ready: got %b want 1", bus.cmd_ready); end
    @(negedge clk);
    checks++; if (bus.err !== 1'b0 || bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL ill_pulse: err=%b ready=%b want 0/1", bus.err, bus.cmd_ready); end
    do_cmd(2'd1, 5'h11, 16'h0005);
    checks++; if (bus.err !== 1'b1 || bus.alu_opcode !== 5'h00) begin fails++; $display("FAIL ill_11: err=%b opcode=%h want 1/00", bus.err, bus.alu_opcode); end
    @(negedge clk);
    do_cmd(2'd3, 5'h00, 16'h0000);
    @(negedge clk);
    checks++; if (bus.result_valid !== 1'b1 || bus.result_data !== 16'h0002) begin fails++; $display("FAIL ill_acc: rv=%b data=%h want 1/0002", bus.result_valid, bus.result_data); end
  endtask

  task automatic test_back_to_back();
    int a0, n;
    a0 = add_cycles;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 4) begin
        @(negedge clk);
        n++;
      end
      if (n >= 4) begin
        checks++; fails++;
        $display("FAIL b2b_timeout: cmd %0d ready=%b want 1", i, bus.cmd_ready);
      end
      bus.cmd_op     = (i % 2 == 0) ? 2'd1 : 2'd0;
      bus.cmd_alu_op = 5'h01;
      bus.cmd_data   = 16'h0001;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.cmd_ready !== ((i % 2 == 0) ? 1'b0 : 1'b1)) begin
        fails++;
        $display("FAIL b2b_ready: cmd %0d ready=%b want %b", i, bus.cmd_ready, (i % 2 == 0) ? 1'b0 : 1'b1);
      end
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    do_cmd(2'd3, 5'h00, 16'h0000);
    @(negedge clk);
    checks++; if (bus.result_valid !== 1'b1 || bus.result_data !== 16'h0007) begin fails++; $display("FAIL b2b_acc: rv=%b data=%h want 1/0007", bus.result_valid, bus.result_data); end
    checks++; if (add_cycles - a0 != 5) begin fails++; $display("FAIL b2b_adds: got %0d want 5", add_cycles - a0); end
  endtask

  task automatic test_invariants();
    @(negedge clk);
    checks++; if (both_cnt != 0) begin fails++; $display("FAIL write_writeu_overlap: got %0d want 0", both_cnt); end
    checks++; if (rv_double != 0 || err_double != 0) begin fails++; $display("FAIL double_pulse: rv=%0d err=%0d want 0/0", rv_double, err_double); end
    checks++; if (err_cnt != 2) begin fails++; $display("FAIL err_count: got %0d want 2", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_exec_add();
    test_compare();
    test_illegal();
    test_back_to_back();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
